md_sequencer: RTL and testbench

Sequencing controller for the HI/LO multiply/divide resource.
- Accepts a one-cycle start command for MULT or DIV from Unidade_Controle and runs the iterative algorithm over WIDTH cycles.
- Drives done, busy and div-by-zero status back to the control unit.
- Drives the result words plus write enables for the Hi and Lo registers.
- Replaces the separate Mult_Hi/Div_Hi and Mult_Lo/Div_Lo source pairs with one sequenced source.

---
 rtl/md_sequencer_if.sv | 35 +++
 rtl/md_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_md_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer_if
// Description : Command/status/result bundle between the control unit and
//               the HI/LO multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             mult_start;
   logic             div_start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             hi_write;
   logic             lo_write;

   // Control-unit side: issues commands, observes status and results
   modport master (
      output mult_start, div_start, op_a, op_b,
      input  busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
   );

   // Sequencer side
   modport slave (
      input  mult_start, div_start, op_a, op_b,
      output busy, done, div_zero, hi_out, lo_out, hi_write, lo_write
   );
endinterface
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : Iterative signed multiply (radix-2 Booth) and signed divide
//               (restoring, on magnitudes) feeding the HI/LO registers.
//               One operation at a time; starts while busy are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           reset,   // asynchronous, active low
   md_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   // Booth: r_acc is one bit wider than WIDTH so subtracting the most
   // negative multiplicand cannot overflow. Divide: r_acc holds the partial
   // remainder (top bit always 0).
   logic [WIDTH:0]     r_acc;
   logic [WIDTH-1:0]   r_mq;      // multiplier / dividend-then-quotient
   logic               r_q1;      // Booth q(-1) bit
   logic [WIDTH-1:0]   r_mcand;   // multiplicand / divisor magnitude
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic               r_busy;
   logic               r_done;
   logic               r_div_zero;
   logic               r_hi_write;
   logic               r_lo_write;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_do_mult;
   logic               w_do_div;
   logic               w_b_zero;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mcand_x;
   logic [WIDTH:0]     w_booth_sum;
   logic [2*WIDTH+1:0] w_booth_cat;
   logic [WIDTH:0]     w_acc_n;
   logic [WIDTH-1:0]   w_mq_booth;
   logic [WIDTH:0]     w_trial;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_rem_n;
   logic [WIDTH-1:0]   w_mq_div;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic               w_fin_dz;

   // MULT wins when both starts arrive together
   assign w_do_mult = bus.mult_start;
   assign w_do_div  = bus.div_start & ~bus.mult_start;
   assign w_b_zero  = (bus.op_b == '0);
   assign w_abs_a   = bus.op_a[WIDTH-1] ? (-bus.op_a) : bus.op_a;
   assign w_abs_b   = bus.op_b[WIDTH-1] ? (-bus.op_b) : bus.op_b;

   // Booth step: add/subtract on the {q0, q-1} pair, then arithmetic shift
   assign w_mcand_x = {r_mcand[WIDTH-1], r_mcand};
   always_comb begin
      w_booth_sum = r_acc;
      case ({r_mq[0], r_q1})
         2'b01:   w_booth_sum = r_acc + w_mcand_x;
         2'b10:   w_booth_sum = r_acc - w_mcand_x;
         default: w_booth_sum = r_acc;
      endcase
   end
   assign w_booth_cat = {w_booth_sum[WIDTH], w_booth_sum, r_mq};
   assign w_acc_n     = w_booth_cat[2*WIDTH+1:WIDTH+1];
   assign w_mq_booth  = w_booth_cat[WIDTH:1];

   // Restoring divide step: shift in next dividend bit, trial subtract
   assign w_trial  = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]} - {1'b0, r_mcand};
   assign w_qbit   = ~w_trial[WIDTH];
   assign w_rem_n  = w_qbit ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
   assign w_mq_div = {r_mq[WIDTH-2:0], w_qbit};

   // Sign fix-up: truncation toward zero, remainder follows the dividend
   assign w_quot = r_neg_q ? (-r_mq) : r_mq;
   assign w_rem  = r_neg_r ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

   // The DONE entered from FIX with the zero-divisor flag is a status-only end
   assign w_fin_dz = (r_state == S_FIX) & r_dz;

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_do_mult)
               w_next = S_MULT;
            else if (w_do_div)
               // Zero divisor skips the iterations; FIX gives it the
               // one-edge delay before DONE
               w_next = w_b_zero ? S_FIX : S_DIV;
         end
         S_MULT:  if (r_cnt == c_last) w_next = S_DONE;
         S_DIV:   if (r_cnt == c_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mq    <= '0;
         r_q1    <= 1'b0;
         r_mcand <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_do_mult) begin
                  r_mcand <= bus.op_a;
                  r_mq    <= bus.op_b;
                  r_acc   <= '0;
                  r_q1    <= 1'b0;
                  r_dz    <= 1'b0;
               end else if (w_do_div) begin
                  r_mcand <= w_abs_b;
                  r_mq    <= w_abs_a;
                  r_acc   <= '0;
                  r_neg_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                  r_neg_r <= bus.op_a[WIDTH-1];
                  r_dz    <= w_b_zero;
               end
            end
            S_MULT: begin
               r_acc <= w_acc_n;
               r_mq  <= w_mq_booth;
               r_q1  <= r_mq[0];
               r_cnt <= r_cnt + c_one;
               if (r_cnt == c_last) begin
                  r_hi <= w_acc_n[WIDTH-1:0];
                  r_lo <= w_mq_booth;
               end
            end
            S_DIV: begin
               r_acc <= {1'b0, w_rem_n};
               r_mq  <= w_mq_div;
               r_cnt <= r_cnt + c_one;
            end
            S_FIX: begin
               if (!r_dz) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered status and write-enable outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi_write <= 1'b0;
         r_lo_write <= 1'b0;
      end else begin
         r_busy     <= (w_next != S_IDLE);
         r_done     <= (w_next == S_DONE);
         r_div_zero <= (w_next == S_DONE) & w_fin_dz;
         r_hi_write <= (w_next == S_DONE) & ~w_fin_dz;
         r_lo_write <= (w_next == S_DONE) & ~w_fin_dz;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.div_zero = r_div_zero;
   assign bus.hi_write = r_hi_write;
   assign bus.lo_write = r_lo_write;
   assign bus.hi_out   = r_hi;
   assign bus.lo_out   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sequencer
// Description : Scoreboard bench for md_sequencer. Expected HI/LO/status and
//               latency are computed from 64-bit signed reference arithmetic
//               when each command is issued and compared on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;
   localparam int W = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   md_sequencer_if #(.WIDTH(W)) bus ();

   md_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
      int           start;
      string        tag;
   } exp_t;

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   bit           chk_idle_next = 1'b0;
   bit           mon_en = 1'b0;
   logic [W-1:0] ra, rb;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Issue one command at a negedge and push its expected outcome
   task automatic start_op(input string tag, input bit m, input bit d,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic signed [63:0] sa, sb, p, q, r;
      int t;
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (bus.busy) check({tag, "_wait_idle"}, 64'(bus.busy), 64'd0);
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      e.tag   = tag;
      e.start = cyc + 1;
      if (m) begin
         p    = sa * sb;
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.dz = 1'b0;
         e.lat = W;
      end else if (b == '0) begin
         e.hi = m_hi;
         e.lo = m_lo;
         e.dz = 1'b1;
         e.lat = 1;
      end else begin
         q    = sa / sb;
         r    = sa % sb;
         e.hi = r[31:0];
         e.lo = q[31:0];
         e.dz = 1'b0;
         e.lat = W + 1;
      end
      m_hi = e.hi;
      m_lo = e.lo;
      sb_q.push_back(e);
      bus.op_a = a;
      bus.op_b = b;
      bus.mult_start = m;
      bus.div_start  = d;
      @(negedge clk);
      bus.mult_start = 1'b0;
      bus.div_start  = 1'b0;
      bus.op_a = ~a;    // operands must have been captured already
      bus.op_b = ~b;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || bus.busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("timeout", 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: compare every done against the scoreboard head
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && mon_en) begin
            if (chk_idle_next) begin
               check("busy_after_done", 64'(bus.busy), 64'd0);
               chk_idle_next = 1'b0;
            end
            if (bus.done) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 64'(bus.done), 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check({e.tag, "_hi"},  64'(bus.hi_out),   64'(e.hi));
                  check({e.tag, "_lo"},  64'(bus.lo_out),   64'(e.lo));
                  check({e.tag, "_dz"},  64'(bus.div_zero), 64'(e.dz));
                  check({e.tag, "_hw"},  64'(bus.hi_write), 64'(!e.dz));
                  check({e.tag, "_lw"},  64'(bus.lo_write), 64'(!e.dz));
                  check({e.tag, "_busy"}, 64'(bus.busy),    64'd1);
                  check({e.tag, "_lat"}, 64'(cyc - e.start), 64'(e.lat));
                  chk_idle_next = 1'b1;
               end
            end else begin
               check("status_idle", 64'({bus.hi_write, bus.lo_write, bus.div_zero}), 64'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.mult_start = 1'b0;
      bus.div_start  = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_flags", 64'({bus.busy, bus.done, bus.div_zero, bus.hi_write, bus.lo_write}), 64'd0);
      check("rst_hi", 64'(bus.hi_out), 64'd0);
      check("rst_lo", 64'(bus.lo_out), 64'd0);
      reset  = 1'b1;
      mon_en = 1'b1;

      start_op("mul_7xm3", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD); wait_done();
      start_op("div_m7d2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002); wait_done();
      start_op("div_ovf",  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
      start_op("div_pn",   1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9); wait_done();
      start_op("div_nn",   1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9); wait_done();
      start_op("div_small",1'b0, 1'b1, 32'd3,         32'd10);        wait_done();

      // Load a known HI/LO, then divide by zero must leave it untouched
      start_op("mul_prior",1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010); wait_done();
      start_op("div_zero", 1'b0, 1'b1, 32'd5,         32'd0);         wait_done();

      // div_start mid-MULT is ignored
      start_op("mul_busy", 1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_0003);
      repeat (10) @(negedge clk);
      bus.div_start = 1'b1;
      bus.op_b = '0;
      @(negedge clk);
      bus.div_start = 1'b0;
      wait_done();

      // Simultaneous starts: MULT wins
      start_op("both", 1'b1, 1'b1, 32'd6, 32'd7); wait_done();

      start_op("mul_minmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000); wait_done();
      start_op("mul_m1m1",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
      start_op("mul_minmax", 1'b1, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF); wait_done();

      for (int i = 0; i < 5; i++) begin
         ra = $urandom;
         rb = $urandom;
         start_op("mul_rnd", 1'b1, 1'b0, ra, rb); wait_done();
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         if (rb == '0) rb = 32'd1;
         start_op("div_rnd", 1'b0, 1'b1, ra, rb); wait_done();
      end

      // Reset mid-DIV: abort with no done, everything cleared
      start_op("div_abort", 1'b0, 1'b1, 32'd1000, 32'd3);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_flags", 64'({bus.busy, bus.done, bus.div_zero, bus.hi_write, bus.lo_write}), 64'd0);
      check("abort_hi", 64'(bus.hi_out), 64'd0);
      check("abort_lo", 64'(bus.lo_out), 64'd0);
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      chk_idle_next = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      start_op("mul_after_rst", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000); wait_done();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
